// File: rtl/dreg_arb_pkg.sv
// Shared types and constants for the shared-register write arbiter.
package dreg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } arb_state_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/dreg_cell.sv
// Enable-gated D cell with synchronous active-high reset.
module dreg_cell (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= 1'b0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or above ptr_i, wrapping at N-1.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    int j;

    // Scan from the farthest offset down so the nearest hit overwrites.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req_i[IW'(j)]) begin
                idx_o   = IW'(j);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dreg_write_arbiter.sv
// Round-robin arbiter granting N requesters write access to one shared
// register, with a post-write lock-out of HOLD cycles.
module dreg_write_arbiter
    import dreg_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N-1:0]           REQ,
    input  logic [N*WIDTH-1:0]     WDATA,
    output logic [N-1:0]           ACK,
    output logic [$clog2(N)-1:0]   GNT_ID,
    output logic                   BUSY,
    output logic [WIDTH-1:0]       Q
);

    localparam int IW = $clog2(N);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             en;
    logic [WIDTH-1:0] d;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic [WIDTH-1:0] wd [N];

    for (genvar i = 0; i < N; i++) begin : g_wd
        assign wd[i] = WDATA[i*WIDTH +: WIDTH];
    end

    rr_pick #(.N(N)) u_pick (
        .req_i   (REQ),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        en      = 1'b0;
        ACK     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_WRITE;
                    gnt_d   = pick_idx;
                end
            end
            ST_WRITE: begin
                // A withdrawn request forfeits the slot without moving the pointer.
                if (REQ[gnt_q]) begin
                    en         = 1'b1;
                    ACK[gnt_q] = 1'b1;
                    if (gnt_q == IW'(N - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gnt_q + 1'b1;
                    end
                    if (HOLD > 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_W'(HOLD - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign d      = wd[gnt_q];
    assign BUSY   = (state_q != ST_IDLE);
    assign GNT_ID = gnt_q;

    for (genvar b = 0; b < WIDTH; b++) begin : g_cell
        dreg_cell u_cell (
            .clk_i (CLK),
            .rst_i (RST),
            .en_i  (en),
            .d_i   (d[b]),
            .q_o   (Q[b])
        );
    end

endmodule

// File: tb/tb_dreg_write_arbiter.sv
// Scenario bench for dreg_write_arbiter with a transaction-level reference model.
module tb_dreg_write_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int HD = 2;
    localparam int IW = 2;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic              RST = 1'b0;
    logic [NR-1:0]     REQ = '0;
    logic [NR*W-1:0]   WDATA = '0;
    logic [NR-1:0]     ACK;
    logic [IW-1:0]     GNT_ID;
    logic              BUSY;
    logic [W-1:0]      Q;

    logic              RST0 = 1'b1;
    logic [NR-1:0]     REQ0 = '0;
    logic [NR*W-1:0]   WDATA0 = '0;
    logic [NR-1:0]     ACK0;
    logic [IW-1:0]     GNT0;
    logic              BUSY0;
    logic [W-1:0]      Q0;

    dreg_write_arbiter #(.N(NR), .WIDTH(W), .HOLD(HD)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WDATA(WDATA),
        .ACK(ACK), .GNT_ID(GNT_ID), .BUSY(BUSY), .Q(Q)
    );

    dreg_write_arbiter #(.N(NR), .WIDTH(W), .HOLD(0)) dut0 (
        .CLK(CLK), .RST(RST0), .REQ(REQ0), .WDATA(WDATA0),
        .ACK(ACK0), .GNT_ID(GNT0), .BUSY(BUSY0), .Q(Q0)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending grant (-1 = none), lock-out cycles left.
    int          m_pend = -1;
    int          m_lock = 0;
    int          m_ptr  = 0;
    int          m_gid  = 0;
    logic [W-1:0] m_q   = '0;

    logic [NR-1:0] e_ack;
    logic          e_busy;
    logic [IW-1:0] e_gid;
    logic [W-1:0]  e_q;

    task automatic model_cycle(input logic [NR-1:0] r,
                               input logic [NR*W-1:0] wd,
                               input bit rst);
        e_ack  = '0;
        e_busy = (m_pend >= 0) || (m_lock > 0);
        e_gid  = IW'(m_gid);
        e_q    = m_q;
        if (m_pend >= 0 && r[m_pend]) e_ack[m_pend] = 1'b1;
        if (rst) begin
            m_pend = -1; m_lock = 0; m_ptr = 0; m_gid = 0; m_q = '0;
        end else if (m_pend >= 0) begin
            if (r[m_pend]) begin
                m_q    = wd[m_pend*W +: W];
                m_ptr  = (m_pend + 1) % NR;
                m_lock = HD;
            end
            m_pend = -1;
        end else if (m_lock > 0) begin
            m_lock--;
        end else if (r != 0) begin
            for (int k = NR - 1; k >= 0; k--) begin
                if (r[(m_ptr + k) % NR]) m_pend = (m_ptr + k) % NR;
            end
            m_gid = m_pend;
        end
    endtask

    task automatic step(input logic [NR-1:0] r,
                        input logic [NR*W-1:0] wd,
                        input bit rst);
        @(negedge CLK);
        REQ = r; WDATA = wd; RST = rst;
        model_cycle(r, wd, rst);
        #1;
    endtask

    function automatic int onehot_idx(input logic [NR-1:0] v);
        int r = -1;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic test_reset();
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);
        n_checks++;
        if (ACK !== '0) $display("FAIL reset_ack got=%b exp=0000", ACK);
        else n_pass++;
        n_checks++;
        if (BUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", BUSY);
        else n_pass++;
        n_checks++;
        if (Q !== 8'h00) $display("FAIL reset_q got=%h exp=00", Q);
        else n_pass++;
        n_checks++;
        if (GNT_ID !== '0) $display("FAIL reset_gnt got=%0d exp=0", GNT_ID);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [NR*W-1:0] wd = '0;
        int ack_cyc = -1;
        int busy_n  = 0;
        wd[7:0] = 8'hA5;
        for (int c = 1; c <= 7; c++) begin
            step((ack_cyc < 0) ? 4'b0001 : 4'b0000, wd, 1'b0);
            n_checks++;
            if (ACK !== e_ack) $display("FAIL single_ack c=%0d got=%b exp=%b", c, ACK, e_ack);
            else n_pass++;
            if (ACK[0] && ack_cyc < 0) ack_cyc = c;
            if (BUSY === 1'b1) busy_n++;
            if (c == 3) begin
                n_checks++;
                if (Q !== 8'hA5) $display("FAIL single_q got=%h exp=a5", Q);
                else n_pass++;
            end
        end
        n_checks++;
        if (ack_cyc != 2) $display("FAIL single_latency got=%0d exp=2", ack_cyc);
        else n_pass++;
        n_checks++;
        if (busy_n != 3) $display("FAIL single_busy got=%0d exp=3", busy_n);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [NR*W-1:0] wd = {8'h44, 8'h33, 8'h22, 8'h11};
        int idx [5] = '{-1, -1, -1, -1, -1};
        int cyc [5] = '{-1, -1, -1, -1, -1};
        int n = 0;
        step('0, '0, 1'b1);
        for (int c = 0; c < 25; c++) begin
            step(4'hF, wd, 1'b0);
            n_checks++;
            if (ACK !== e_ack || Q !== e_q)
                $display("FAIL rr_cycle c=%0d ack=%b/%b q=%h/%h", c, ACK, e_ack, Q, e_q);
            else n_pass++;
            if (ACK != 0 && n < 5) begin
                idx[n] = onehot_idx(ACK);
                cyc[n] = c;
                n++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (idx[k] != k % NR) $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, idx[k], k % NR);
            else n_pass++;
            if (k > 0) begin
                n_checks++;
                if (cyc[k] - cyc[k-1] != 4)
                    $display("FAIL rr_spacing k=%0d got=%0d exp=4", k, cyc[k] - cyc[k-1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [NR*W-1:0] wd = {8'h3D, 8'h2C, 8'h1B, 8'h0A};
        bit got = 0;
        int first [2] = '{-1, -1};
        int n = 0;
        step('0, '0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            step(got ? 4'b0000 : 4'b0100, wd, 1'b0);
            if (ACK[2]) got = 1;
        end
        n_checks++;
        if (!got) $display("FAIL wrap_prime got=0 exp=1");
        else n_pass++;
        for (int c = 0; c < 10; c++) begin
            step(4'b0101, wd, 1'b0);
            if (ACK != 0 && n < 2) begin
                first[n] = onehot_idx(ACK);
                n++;
            end
        end
        n_checks++;
        if (first[0] != 0) $display("FAIL wrap_first got=%0d exp=0", first[0]);
        else n_pass++;
        n_checks++;
        if (first[1] != 2) $display("FAIL wrap_second got=%0d exp=2", first[1]);
        else n_pass++;
        n_checks++;
        if (Q !== e_q) $display("FAIL wrap_q got=%h exp=%h", Q, e_q);
        else n_pass++;
    endtask

    task automatic test_withdraw();
        logic [NR*W-1:0] wd = {8'h03, 8'h02, 8'h3C, 8'h01};
        step('0, '0, 1'b1);
        step(4'b0010, wd, 1'b0);
        step(4'b0000, wd, 1'b0);
        n_checks++;
        if (ACK !== 4'b0000 || BUSY !== 1'b1)
            $display("FAIL withdraw_write ack=%b busy=%b exp ack=0000 busy=1", ACK, BUSY);
        else n_pass++;
        step(4'b0000, wd, 1'b0);
        n_checks++;
        if (Q !== 8'h00 || BUSY !== 1'b0)
            $display("FAIL withdraw_after q=%h busy=%b exp q=00 busy=0", Q, BUSY);
        else n_pass++;
        step(4'b1001, wd, 1'b0);
        step(4'b1001, wd, 1'b0);
        n_checks++;
        if (ACK !== 4'b0001 || GNT_ID !== 2'd0)
            $display("FAIL withdraw_regrant ack=%b gnt=%0d exp ack=0001 gnt=0", ACK, GNT_ID);
        else n_pass++;
        step(4'b0000, wd, 1'b0);
        n_checks++;
        if (Q !== 8'h01) $display("FAIL withdraw_q got=%h exp=01", Q);
        else n_pass++;
        step(4'b0000, wd, 1'b0);
        step(4'b0000, wd, 1'b0);
    endtask

    task automatic test_reset_in_write();
        logic [NR*W-1:0] wd = '0;
        bit got = 0;
        step('0, '0, 1'b1);
        wd[7:0] = 8'h5A;
        for (int c = 0; c < 6; c++) begin
            step(got ? 4'b0000 : 4'b0001, wd, 1'b0);
            if (ACK[0]) got = 1;
        end
        n_checks++;
        if (Q !== 8'h5A) $display("FAIL rstw_pre q=%h exp=5a", Q);
        else n_pass++;
        wd[7:0] = 8'hFF;
        step(4'b0001, wd, 1'b0);
        step(4'b0001, wd, 1'b1);
        step(4'b0001, wd, 1'b0);
        n_checks++;
        if (Q !== 8'h00) $display("FAIL rstw_q got=%h exp=00", Q);
        else n_pass++;
        n_checks++;
        if (ACK !== 4'b0000 || BUSY !== 1'b0)
            $display("FAIL rstw_idle ack=%b busy=%b exp ack=0000 busy=0", ACK, BUSY);
        else n_pass++;
        step(4'b0000, wd, 1'b0);
        step(4'b0000, wd, 1'b0);
    endtask

    task automatic test_random();
        logic [NR-1:0]   rq = '0;
        logic [NR*W-1:0] wd = '0;
        logic [NR-1:0]   prev_ack = '0;
        step('0, '0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (rq[i]) begin
                    if (prev_ack[i]) begin
                        if ($urandom_range(1, 0) == 0) rq[i] = 1'b0;
                        else wd[i*W +: W] = W'($urandom);
                    end else if ($urandom_range(19, 0) == 0) begin
                        rq[i] = 1'b0;
                    end
                end else if ($urandom_range(9, 0) < 3) begin
                    rq[i] = 1'b1;
                    wd[i*W +: W] = W'($urandom);
                end
            end
            step(rq, wd, ($urandom_range(99, 0) == 0));
            prev_ack = e_ack;
            n_checks++;
            if (ACK !== e_ack || BUSY !== e_busy || GNT_ID !== e_gid || Q !== e_q)
                $display("FAIL random c=%0d ack=%b/%b busy=%b/%b gnt=%0d/%0d q=%h/%h",
                         c, ACK, e_ack, BUSY, e_busy, GNT_ID, e_gid, Q, e_q);
            else n_pass++;
        end
    endtask

    task automatic test_hold0();
        logic [NR-1:0] exp_ack;
        @(negedge CLK);
        RST0 = 1'b1;
        @(negedge CLK);
        RST0 = 1'b0;
        REQ0 = 4'b0011;
        WDATA0 = {8'h00, 8'h00, 8'hB2, 8'hB1};
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c % 2 == 1) exp_ack = ((c / 2) % 2 == 0) ? 4'b0001 : 4'b0010;
            else exp_ack = 4'b0000;
            n_checks++;
            if (ACK0 !== exp_ack) $display("FAIL hold0_ack c=%0d got=%b exp=%b", c, ACK0, exp_ack);
            else n_pass++;
            @(negedge CLK);
        end
        REQ0 = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_withdraw();
        test_reset_in_write();
        test_random();
        test_hold0();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
